step02_twf_mult: RTL

// - Step-02 twiddle-multiply stage of the 512-pt FFT; reads the step-02 twiddle ROM pair (re/im, 2.7 fmt).
// - Streams complex samples in, counts position in frame, drives ROM index, returns data*twf rounded/saturated.
// - Sits between step-01 butterfly output and step-02 butterfly input; single lane, valid/ready both sides.

---
 rtl/step02_twf_mult_pkg.sv | 31 +++
 rtl/step02_twf_mult_if.sv | 48 ++++
 rtl/step02_twf_mult_cmul_rnd.sv | 96 +++++++++
 rtl/step02_twf_mult.sv | 83 ++++++++
 4 files changed

// File: rtl/step02_twf_mult_pkg.sv
// Shared constants, sample types and index helper for the step-02 twiddle
// multiply stage of the 512-point FFT.
package step02_pkg;

  localparam int N_PT   = 512;
  localparam int IDX_W  = $clog2(N_PT);
  localparam int DATA_W = 11;
  localparam int TWF_W  = 9;
  localparam int FRAC_W = 7;
  localparam int OUT_W  = 12;
  // One extra bit over a single product holds the sum/difference of two products
  localparam int PROD_W = DATA_W + TWF_W + 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_PT - 1);

  typedef struct packed {
    logic signed [DATA_W-1:0] re;
    logic signed [DATA_W-1:0] im;
  } cplx_in_t;

  typedef struct packed {
    logic signed [OUT_W-1:0] re;
    logic signed [OUT_W-1:0] im;
  } cplx_out_t;

  // Successor of a frame position, wrapping N_PT-1 back to 0
  function automatic logic [IDX_W-1:0] idx_next(input logic [IDX_W-1:0] idx);
    return (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
  endfunction

endpackage

// File: rtl/step02_twf_mult_if.sv
// Stream, twiddle-ROM and status bundle of the step-02 twiddle multiplier.
// slave  = the multiplier's view, master = the surrounding datapath's view.
interface step02_twf_mult_if;
  import step02_pkg::*;

  // Input stream from the step-01 butterfly
  logic                     din_valid;
  logic                     din_ready;
  logic                     din_first;
  logic signed [DATA_W-1:0] din_re;
  logic signed [DATA_W-1:0] din_im;

  // Combinational twiddle ROM pair
  logic [IDX_W-1:0]         twf_idx;
  logic signed [TWF_W-1:0]  twf_re;
  logic signed [TWF_W-1:0]  twf_im;

  // Output stream to the step-02 butterfly
  logic                     dout_valid;
  logic                     dout_ready;
  logic                     dout_last;
  logic signed [OUT_W-1:0]  dout_re;
  logic signed [OUT_W-1:0]  dout_im;

  // Sticky framing error
  logic                     err_frame;

  modport slave (
    input  din_valid, din_first, din_re, din_im,
    output din_ready,
    output twf_idx,
    input  twf_re, twf_im,
    output dout_valid, dout_last, dout_re, dout_im,
    input  dout_ready,
    output err_frame
  );

  modport master (
    output din_valid, din_first, din_re, din_im,
    input  din_ready,
    input  twf_idx,
    output twf_re, twf_im,
    input  dout_valid, dout_last, dout_re, dout_im,
    output dout_ready,
    input  err_frame
  );

endinterface

// File: rtl/step02_twf_mult_cmul_rnd.sv
// Complex multiply of a sample by a twiddle (S2), then round-half-up and
// saturate to the output width (S3). Both stages advance only on en_i.
module step02_cmul_rnd
  import step02_pkg::*;
(
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    en_i,
  input  logic                    vld_i,
  input  logic                    last_i,
  input  cplx_in_t                din_i,
  input  logic signed [TWF_W-1:0] twf_re_i,
  input  logic signed [TWF_W-1:0] twf_im_i,
  output logic                    vld_o,
  output logic                    last_o,
  output cplx_out_t               dout_o
);

  localparam logic signed [PROD_W-1:0] RND_HALF = PROD_W'(1 << (FRAC_W - 1));
  localparam logic signed [PROD_W-1:0] SAT_MAX  = PROD_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [PROD_W-1:0] SAT_MIN  = ~SAT_MAX;

  function automatic logic signed [PROD_W-1:0] sext_data(input logic signed [DATA_W-1:0] x);
    return $signed({{(PROD_W-DATA_W){x[DATA_W-1]}}, x});
  endfunction

  function automatic logic signed [PROD_W-1:0] sext_twf(input logic signed [TWF_W-1:0] x);
    return $signed({{(PROD_W-TWF_W){x[TWF_W-1]}}, x});
  endfunction

  // Add half an output LSB, then drop the twiddle fraction (floor)
  function automatic logic signed [PROD_W-1:0] rnd_half_up(input logic signed [PROD_W-1:0] p);
    logic signed [PROD_W-1:0] s;
    s = p + RND_HALF;
    return s >>> FRAC_W;
  endfunction

  // Clamp to the signed output range
  function automatic logic signed [OUT_W-1:0] sat_out(input logic signed [PROD_W-1:0] v);
    logic signed [OUT_W-1:0] r;
    if (v > SAT_MAX)      r = SAT_MAX[OUT_W-1:0];
    else if (v < SAT_MIN) r = SAT_MIN[OUT_W-1:0];
    else                  r = v[OUT_W-1:0];
    return r;
  endfunction

  logic signed [PROD_W-1:0] a, b, c, d;
  logic signed [PROD_W-1:0] pr_d, pi_d;
  logic signed [PROD_W-1:0] pr_p2_q, pi_p2_q;
  logic                     vld_p2_q, last_p2_q;
  logic                     vld_p3_q, last_p3_q;
  cplx_out_t                dout_p3_q;

  // Full-precision complex product of the S1 sample and the ROM twiddle
  always_comb begin
    a    = sext_data(din_i.re);
    b    = sext_data(din_i.im);
    c    = sext_twf(twf_re_i);
    d    = sext_twf(twf_im_i);
    pr_d = a * c - b * d;
    pi_d = a * d + b * c;
  end

  // ---- S2: product registers ----
  // Product data carries no reset; its valid flag qualifies it
  always_ff @(posedge clk) begin
    if (en_i) begin
      pr_p2_q <= pr_d;
      pi_p2_q <= pi_d;
    end
  end

  // ---- S3: round/saturate into the output registers ----
  // Control of S2/S3 and the visible output word clear on reset
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_p2_q  <= 1'b0;
      last_p2_q <= 1'b0;
      vld_p3_q  <= 1'b0;
      last_p3_q <= 1'b0;
      dout_p3_q <= '0;
    end else if (en_i) begin
      vld_p2_q  <= vld_i;
      last_p2_q <= last_i;
      vld_p3_q  <= vld_p2_q;
      last_p3_q <= last_p2_q;
      dout_p3_q <= '{re: sat_out(rnd_half_up(pr_p2_q)),
                     im: sat_out(rnd_half_up(pi_p2_q))};
    end
  end

  assign vld_o  = vld_p3_q;
  assign last_o = last_p3_q;
  assign dout_o = dout_p3_q;

endmodule

// File: rtl/step02_twf_mult.sv
// Step-02 twiddle multiply stage: counts the position of each accepted sample
// in its frame, addresses the external twiddle ROM with it and streams out
// sample*twiddle, rounded and saturated. One global stall freezes all stages.
module step02_twf_mult
  import step02_pkg::*;
(
  input  logic               clk,
  input  logic               rstn,
  step02_twf_mult_if.slave   bus
);

  logic             adv;
  logic             acc;
  logic [IDX_W-1:0] idx_sel;
  logic [IDX_W-1:0] cnt_d, cnt_q;
  logic [IDX_W-1:0] idx_p1_q;
  logic             vld_p1_q;
  logic             err_q;
  cplx_in_t         din_p1_q;
  logic             vld_p3;
  logic             last_p3;
  cplx_out_t        dout_p3;

  // The pipeline moves only when the output slot is free or being drained
  assign adv     = !vld_p3 || bus.dout_ready;
  assign acc     = bus.din_valid && adv;
  // A frame marker forces the position back to 0, otherwise keep counting
  assign idx_sel = bus.din_first ? '0 : cnt_q;
  assign cnt_d   = idx_next(idx_sel);

  // ---- S1: input sample and frame position ----
  // Frame counter, S1 index/valid and the sticky framing error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q    <= '0;
      idx_p1_q <= '0;
      vld_p1_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      if (acc) begin
        cnt_q    <= cnt_d;
        idx_p1_q <= idx_sel;
        if (bus.din_first && (cnt_q != '0)) begin
          err_q <= 1'b1;
        end
      end
      if (adv) begin
        vld_p1_q <= bus.din_valid;
      end
    end
  end

  // S1 sample data, qualified by vld_p1_q
  always_ff @(posedge clk) begin
    if (acc) begin
      din_p1_q <= '{re: bus.din_re, im: bus.din_im};
    end
  end

  // ---- S2/S3: multiply, round and saturate ----
  step02_cmul_rnd u_cmul_rnd (
    .clk      (clk),
    .rstn     (rstn),
    .en_i     (adv),
    .vld_i    (vld_p1_q),
    .last_i   (idx_p1_q == IDX_LAST),
    .din_i    (din_p1_q),
    .twf_re_i (bus.twf_re),
    .twf_im_i (bus.twf_im),
    .vld_o    (vld_p3),
    .last_o   (last_p3),
    .dout_o   (dout_p3)
  );

  assign bus.din_ready  = adv;
  assign bus.twf_idx    = idx_p1_q;
  assign bus.dout_valid = vld_p3;
  assign bus.dout_last  = last_p3;
  assign bus.dout_re    = dout_p3.re;
  assign bus.dout_im    = dout_p3.im;
  assign bus.err_frame  = err_q;

endmodule
